// File: rtl/edge_oneshot_pkg.sv
// Shared definitions for the multi-channel debounced edge oneshot:
// mode encodings, repeat FSM states and counter sizing helpers.
package edge_oneshot_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'b00,
    RPT_HOLD   = 2'b01,
    RPT_REPEAT = 2'b10
  } rpt_state_e;

  // Bits needed for a counter spanning 0..max_count
  function automatic int cnt_width(input int unsigned max_count);
    return (max_count == 0) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_oneshot_ch.sv
// One channel: input synchroniser, stable-count debounce, selectable edge
// pulse and hold-to-repeat FSM.
module edge_oneshot_ch
  import edge_oneshot_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int RPT_CYCLES  = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [1:0] mode,
  input  logic       rpt_en,
  output logic       level_db,
  output logic       pulse,
  output logic       pulse_nxt
);

  localparam int DBW = cnt_width(DB_CYCLES);
  localparam int RW  = cnt_width(max_u(HOLD_CYCLES, RPT_CYCLES));
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]  HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0]  RPT_LAST  = RW'(RPT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DBW-1:0]         db_cnt;
  logic                   level_d;
  logic                   rise;
  logic                   fall;
  logic                   rise_en;
  logic                   fall_en;
  logic                   rpt_fire;
  rpt_state_e             state, state_nxt;
  logic [RW-1:0]          rpt_cnt, rpt_cnt_nxt;

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = level_db & ~level_d;
  assign fall = ~level_db & level_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      db_cnt   <= '0;
      level_db <= 1'b0;
      level_d  <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      level_d <= level_db;
      pulse   <= pulse_nxt;
      if (sync != level_db) begin
        if (db_cnt == DB_LAST) begin
          level_db <= ~level_db;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RPT_IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

  // A release or disable aborts the repeat sequence from any state
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    if (fall || !rpt_en) begin
      state_nxt   = RPT_IDLE;
      rpt_cnt_nxt = '0;
    end else begin
      case (state)
        RPT_IDLE: begin
          if (rise) begin
            state_nxt   = RPT_HOLD;
            rpt_cnt_nxt = '0;
          end
        end
        RPT_HOLD: begin
          if (rpt_cnt == HOLD_LAST) begin
            state_nxt   = RPT_REPEAT;
            rpt_cnt_nxt = '0;
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (rpt_cnt == RPT_LAST) rpt_cnt_nxt = '0;
          else                     rpt_cnt_nxt = rpt_cnt + 1'b1;
        end
        default: begin
          state_nxt   = RPT_IDLE;
          rpt_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    rise_en   = (mode_e'(mode) == MODE_RISE) || (mode_e'(mode) == MODE_BOTH);
    fall_en   = (mode_e'(mode) == MODE_FALL) || (mode_e'(mode) == MODE_BOTH);
    rpt_fire  = rpt_en && (((state == RPT_HOLD)   && (rpt_cnt == HOLD_LAST)) ||
                           ((state == RPT_REPEAT) && (rpt_cnt == RPT_LAST)));
    pulse_nxt = (rise && rise_en) || (fall && fall_en) || rpt_fire;
  end

endmodule

// File: rtl/edge_oneshot_multi.sv
// N_CH independent debounced edge oneshots plus a registered any-event flag.
module edge_oneshot_multi
  import edge_oneshot_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int RPT_CYCLES  = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   din,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   rpt_en,
  output logic [N_CH-1:0]   level_db,
  output logic [N_CH-1:0]   pulse,
  output logic              event_any
);

  logic [N_CH-1:0] pulse_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_oneshot_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .RPT_CYCLES  (RPT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .din       (din[i]),
      .mode      (mode[2*i+1:2*i]),
      .rpt_en    (rpt_en[i]),
      .level_db  (level_db[i]),
      .pulse     (pulse[i]),
      .pulse_nxt (pulse_nxt[i])
    );
  end

  // Built from next-state pulses so it lines up with the registered pulse vector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) event_any <= 1'b0;
    else      event_any <= |pulse_nxt;
  end

endmodule

// File: tb/tb_edge_oneshot_multi.sv
// Scoreboard bench for edge_oneshot_multi: stimulus queues expected pulse
// cycles, a negedge monitor matches them against pulse/event_any.
module tb_edge_oneshot_multi;

  logic       clk;
  logic       rst;
  logic [1:0] din;
  logic [3:0] mode;
  logic [1:0] rpt_en;
  logic [1:0] level_db;
  logic [1:0] pulse;
  logic       event_any;

  edge_oneshot_multi #(
    .N_CH        (2),
    .SYNC_STAGES (2),
    .DB_CYCLES   (4),
    .HOLD_CYCLES (8),
    .RPT_CYCLES  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .mode      (mode),
    .rpt_en    (rpt_en),
    .level_db  (level_db),
    .pulse     (pulse),
    .event_any (event_any)
  );

  typedef struct {
    int         at_cyc;
    logic [1:0] p;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // After edge E the negedge monitor sees cyc == E
  always @(negedge clk) begin
    if (pulse != 2'b00 || event_any) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL pulse_unexpected cyc=%0d pulse=%b event_any=%b required no pulse",
                 cyc, pulse, event_any);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.at_cyc != cyc || pulse != mon_e.p || event_any !== 1'b1) begin
          n_err++;
          $display("FAIL pulse_match cyc=%0d pulse=%b event_any=%b required cyc=%0d pulse=%b event_any=1",
                   cyc, pulse, event_any, mon_e.at_cyc, mon_e.p);
        end
      end
    end else if (q.size() > 0 && q[0].at_cyc < cyc) begin
      n_vec++;
      n_err++;
      mon_e = q.pop_front();
      $display("FAIL pulse_missing cyc=%0d pulse=%b required cyc=%0d pulse=%b",
               cyc, pulse, mon_e.at_cyc, mon_e.p);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [1:0] p);
    exp_t x;
    x.at_cyc = c;
    x.p      = p;
    q.push_back(x);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required finish before time limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; din = '0; mode = '0; rpt_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_level_db", 32'(level_db), 0);
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_event_any", 32'(event_any), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Rise-only press, then release without a pulse
    mode = 4'b0001;
    @(negedge clk);
    din[0] = 1'b1; e = cyc + 1; push(e + 6, 2'b01);
    wait_until(e + 4); chk("t1_lvl_before", 32'(level_db[0]), 0);
    wait_until(e + 5); chk("t1_lvl_after", 32'(level_db[0]), 1);
    wait_until(e + 12);
    din[0] = 1'b0; e = cyc + 1;
    wait_until(e + 5); chk("t1_lvl_release", 32'(level_db[0]), 0);
    wait_until(e + 10);

    // Three-cycle glitch is rejected; then fall-only mode
    din[0] = 1'b1; e = cyc + 1;
    wait_until(e + 2); din[0] = 1'b0;
    wait_until(e + 12); chk("t2_glitch_lvl", 32'(level_db[0]), 0);
    mode = 4'b0010;
    @(negedge clk);
    din[0] = 1'b1; e = cyc + 1;
    wait_until(e + 8); chk("t2_lvl_high", 32'(level_db[0]), 1);
    din[0] = 1'b0; e = cyc + 1; push(e + 6, 2'b01);
    wait_until(e + 12);

    // Both edges, with mode changes while level is stable
    mode = 4'b0011;
    @(negedge clk);
    din[0] = 1'b1; e = cyc + 1; push(e + 6, 2'b01);
    wait_until(e + 8); mode = 4'b0001;
    @(negedge clk); mode = 4'b0010;
    @(negedge clk); mode = 4'b0011;
    wait_until(e + 12);
    din[0] = 1'b0; e = cyc + 1; push(e + 6, 2'b01);
    wait_until(e + 12);

    // Auto-repeat; accepted fall coincides with a repeat -> one pulse
    rpt_en = 2'b01;
    @(negedge clk);
    din[0] = 1'b1; e = cyc + 1;
    push(e + 6, 2'b01); push(e + 14, 2'b01); push(e + 17, 2'b01);
    push(e + 20, 2'b01); push(e + 23, 2'b01);
    wait_until(e + 16); din[0] = 1'b0;
    wait_until(e + 40); chk("t4_lvl_released", 32'(level_db[0]), 0);
    rpt_en = 2'b00;

    // Simultaneous press on both channels
    mode = 4'b0101;
    @(negedge clk);
    din = 2'b11; e = cyc + 1; push(e + 6, 2'b11);
    wait_until(e + 12); chk("t5_lvl_both", 32'(level_db), 3);
    din = 2'b00; e = cyc + 1;
    wait_until(e + 12); chk("t5_lvl_both_rel", 32'(level_db), 0);

    // Reset mid-HOLD with din held high
    mode = 4'b0001; rpt_en = 2'b01;
    @(negedge clk);
    din[0] = 1'b1; e = cyc + 1; push(e + 6, 2'b01);
    wait_until(e + 9); rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_level_db", 32'(level_db), 0);
    chk("t6_rst_pulse", 32'(pulse), 0);
    chk("t6_rst_event_any", 32'(event_any), 0);
    wait_until(e + 11); rst = 1'b1;
    push(e + 18, 2'b01); push(e + 26, 2'b01);
    wait_until(e + 17); chk("t6_lvl_relatch", 32'(level_db[0]), 1);
    wait_until(e + 27); rpt_en = 2'b00;
    wait_until(e + 40); din[0] = 1'b0;
    wait_until(e + 55); chk("t6_lvl_final", 32'(level_db[0]), 0);

    repeat (5) @(negedge clk);
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL pulse_missing_end required cyc=%0d pulse=%b", mon_e.at_cyc, mon_e.p);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
